data_gen_burst_sequencer: RTL and testbench

- Controller that sequences the internal test-data generator.
- Produces the generator's bit strobe (data_clock) from clk via a programmable divider.
- Drives its 4-bit pattern select through a programmed burst: preamble, payload, gap, repeated N times or continuously.
- Sits between the control register bank (config, start/abort) and the data generator.

---
 rtl/data_gen_burst_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_data_gen_burst_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_gen_burst_sequencer.sv
// Burst sequencer for the test-data generator: divides clk into the data_clock bit
// strobe and steps dat_pat through preamble/payload/gap bursts. Optional output
// sync_pulse is enabled with the BURST_SYNC_EN macro.
module data_gen_burst_sequencer #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 16,
    parameter int RPT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [LEN_W-1:0] pre_len,
    input  logic [LEN_W-1:0] pay_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [3:0]       pre_pat,
    input  logic [3:0]       pay_pat,
    input  logic [3:0]       idle_pat,
    input  logic [RPT_W-1:0] burst_cnt,
    output logic             data_clock,
    output logic [3:0]       dat_pat,
    output logic             busy,
    output logic             done,
    output logic [RPT_W-1:0] bursts_done
`ifdef BURST_SYNC_EN
    ,
    output logic             sync_pulse
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_PAY  = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic             dclk_q, dclk_d;
    logic [3:0]       pat_q, pat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RPT_W-1:0] bursts_q, bursts_d;

    logic [DIV_W-1:0] div_cfg_q, div_cfg_d;
    logic [LEN_W-1:0] pre_len_q, pre_len_d;
    logic [LEN_W-1:0] pay_len_q, pay_len_d;
    logic [LEN_W-1:0] gap_len_q, gap_len_d;
    logic [3:0]       pre_pat_q, pre_pat_d;
    logic [3:0]       pay_pat_q, pay_pat_d;
    logic [3:0]       idle_pat_q, idle_pat_d;
    logic [RPT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             term_s;
    logic             fall_s;
    logic [LEN_W-1:0] bit_inc_s;
    logic [LEN_W-1:0] cur_len_s;
    logic [RPT_W-1:0] bursts_inc_s;
    state_t           nxt_s;

    // First phase of a burst; S_FIN means every phase is empty.
    function automatic state_t first_phase(input logic [LEN_W-1:0] p,
                                           input logic [LEN_W-1:0] y,
                                           input logic [LEN_W-1:0] g);
        state_t s;
        if (p != '0) begin
            s = S_PRE;
        end else if (y != '0) begin
            s = S_PAY;
        end else if (g != '0) begin
            s = S_GAP;
        end else begin
            s = S_FIN;
        end
        return s;
    endfunction

    // Phase following cur within a burst; S_FIN marks the end of the burst.
    function automatic state_t next_phase(input state_t cur,
                                          input logic [LEN_W-1:0] y,
                                          input logic [LEN_W-1:0] g);
        state_t s;
        case (cur)
            S_PRE: begin
                if (y != '0) begin
                    s = S_PAY;
                end else if (g != '0) begin
                    s = S_GAP;
                end else begin
                    s = S_FIN;
                end
            end
            S_PAY: begin
                if (g != '0) begin
                    s = S_GAP;
                end else begin
                    s = S_FIN;
                end
            end
            default: s = S_FIN;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] pat_of(input state_t s,
                                          input logic [3:0] p,
                                          input logic [3:0] y,
                                          input logic [3:0] i);
        logic [3:0] r;
        case (s)
            S_PRE:   r = p;
            S_PAY:   r = y;
            default: r = i;
        endcase
        return r;
    endfunction

    // Divider terminal count, falling toggle and current phase length.
    always_comb begin
        term_s       = (div_q == div_cfg_q);
        fall_s       = term_s && dclk_q;
        bit_inc_s    = bit_q + LEN_W'(1);
        bursts_inc_s = (bursts_q == '1) ? bursts_q : bursts_q + RPT_W'(1);
        nxt_s        = next_phase(state_q, pay_len_q, gap_len_q);
        case (state_q)
            S_PRE:   cur_len_s = pre_len_q;
            S_PAY:   cur_len_s = pay_len_q;
            S_GAP:   cur_len_s = gap_len_q;
            default: cur_len_s = '0;
        endcase
    end

    // Next-state and output logic for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        dclk_d      = dclk_q;
        pat_d       = pat_q;
        done_d      = 1'b0;
        bursts_d    = bursts_q;
        div_cfg_d   = div_cfg_q;
        pre_len_d   = pre_len_q;
        pay_len_d   = pay_len_q;
        gap_len_d   = gap_len_q;
        pre_pat_d   = pre_pat_q;
        pay_pat_d   = pay_pat_q;
        idle_pat_d  = idle_pat_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            S_IDLE: begin
                pat_d  = idle_pat;
                div_d  = '0;
                bit_d  = '0;
                dclk_d = 1'b0;
                if (start && !abort) begin
                    div_cfg_d   = clk_div;
                    pre_len_d   = pre_len;
                    pay_len_d   = pay_len;
                    gap_len_d   = gap_len;
                    pre_pat_d   = pre_pat;
                    pay_pat_d   = pay_pat;
                    idle_pat_d  = idle_pat;
                    burst_cnt_d = burst_cnt;
                    bursts_d    = '0;
                    state_d     = first_phase(pre_len, pay_len, gap_len);
                    pat_d       = pat_of(state_d, pre_pat, pay_pat, idle_pat);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE, S_PAY, S_GAP: begin
                if (term_s) begin
                    div_d  = '0;
                    dclk_d = ~dclk_q;
                end else begin
                    div_d  = div_q + DIV_W'(1);
                end
                // A bit period closes on the falling toggle; phase changes only here.
                if (fall_s) begin
                    if (bit_inc_s == cur_len_s) begin
                        bit_d = '0;
                        if (nxt_s != S_FIN) begin
                            state_d = nxt_s;
                            pat_d   = pat_of(nxt_s, pre_pat_q, pay_pat_q, idle_pat_q);
                        end else begin
                            bursts_d = bursts_inc_s;
                            if ((burst_cnt_q == '0) || (bursts_inc_s < burst_cnt_q)) begin
                                state_d = first_phase(pre_len_q, pay_len_q, gap_len_q);
                                pat_d   = pat_of(state_d, pre_pat_q, pay_pat_q, idle_pat_q);
                            end else begin
                                state_d = S_FIN;
                                pat_d   = idle_pat_q;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        bit_d = bit_inc_s;
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            S_FIN: begin
                dclk_d = 1'b0;
                pat_d  = idle_pat_q;
                div_d  = '0;
                bit_d  = '0;
                // An all-empty run enters FIN without done, so it raises done one cycle later.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                pat_d   = idle_pat;
                dclk_d  = 1'b0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            dclk_d  = 1'b0;
            pat_d   = idle_pat;
            div_d   = '0;
            bit_d   = '0;
            done_d  = 1'b0;
        end else begin
            bursts_d = bursts_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counter, output and latched-configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            dclk_q      <= 1'b0;
            pat_q       <= idle_pat;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bursts_q    <= '0;
            div_cfg_q   <= '0;
            pre_len_q   <= '0;
            pay_len_q   <= '0;
            gap_len_q   <= '0;
            pre_pat_q   <= 4'd0;
            pay_pat_q   <= 4'd0;
            idle_pat_q  <= 4'd0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            dclk_q      <= dclk_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bursts_q    <= bursts_d;
            div_cfg_q   <= div_cfg_d;
            pre_len_q   <= pre_len_d;
            pay_len_q   <= pay_len_d;
            gap_len_q   <= gap_len_d;
            pre_pat_q   <= pre_pat_d;
            pay_pat_q   <= pay_pat_d;
            idle_pat_q  <= idle_pat_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign data_clock  = dclk_q;
    assign dat_pat     = pat_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bursts_done = bursts_q;

`ifdef BURST_SYNC_EN
    logic sync_q, sync_d;

    // Rising toggle in the first payload bit (first gap bit when payload is empty).
    always_comb begin
        if (!abort && term_s && !dclk_q && (bit_q == '0) &&
            ((state_q == S_PAY) || ((state_q == S_GAP) && (pay_len_q == '0)))) begin
            sync_d = 1'b1;
        end else begin
            sync_d = 1'b0;
        end
    end

    // Sync pulse register, aligned with the data_clock rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_pulse = sync_q;
`endif

endmodule

// File: tb/tb_data_gen_burst_sequencer.sv
// Directed, table-driven bench for data_gen_burst_sequencer with hand-written
// sequences for abort, reset, mid-run changes and the optional sync pulse.
module tb_data_gen_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] clk_div;
    logic [15:0] pre_len;
    logic [15:0] pay_len;
    logic [15:0] gap_len;
    logic [3:0]  pre_pat;
    logic [3:0]  pay_pat;
    logic [3:0]  idle_pat;
    logic [7:0]  burst_cnt;
    logic        data_clock;
    logic [3:0]  dat_pat;
    logic        busy;
    logic        done;
    logic [7:0]  bursts_done;
`ifdef BURST_SYNC_EN
    logic        sync_pulse;
`endif

    int total = 0;
    int bad   = 0;

    data_gen_burst_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .clk_div    (clk_div),
        .pre_len    (pre_len),
        .pay_len    (pay_len),
        .gap_len    (gap_len),
        .pre_pat    (pre_pat),
        .pay_pat    (pay_pat),
        .idle_pat   (idle_pat),
        .burst_cnt  (burst_cnt),
        .data_clock (data_clock),
        .dat_pat    (dat_pat),
        .busy       (busy),
        .done       (done),
`ifdef BURST_SYNC_EN
        .sync_pulse (sync_pulse),
`endif
        .bursts_done(bursts_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dv;
        logic [15:0] pl;
        logic [15:0] yl;
        logic [15:0] gl;
        logic [3:0]  pp;
        logic [3:0]  yp;
        logic [3:0]  ip;
        logic [7:0]  bc;
        int          e_done;
        int          e_bursts;
        int          e_rises;
        int          e_pre;
        int          e_pay;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        clk_div   = v.dv;
        pre_len   = v.pl;
        pay_len   = v.yl;
        gap_len   = v.gl;
        pre_pat   = v.pp;
        pay_pat   = v.yp;
        idle_pat  = v.ip;
        burst_cnt = v.bc;
    endtask

    // Pulse start, then sample every cycle (k=1 is the cycle after acceptance) until done.
    task automatic run_seq(input int budget, input logic [3:0] pp, input logic [3:0] yp,
                           output int done_k, output int rises, output int pre_c,
                           output int pay_c, output int bd, output int busy_at_done);
        logic prev;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev = 1'b0;
        done_k = -1; rises = 0; pre_c = 0; pay_c = 0; bd = -1; busy_at_done = -1;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (data_clock && !prev) rises++;
            prev = data_clock;
            if (dat_pat == pp) pre_c++;
            if (dat_pat == yp) pay_c++;
            if (done) begin
                done_k = k;
                bd = int'(bursts_done);
                busy_at_done = int'(busy);
                break;
            end
        end
    endtask

    int dk, rs, pc, yc, bd, bz, ndone, c6, c9;
    logic prv;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd1, 16'd4, 16'd8, 16'd2, 4'd1, 4'd2, 4'd0,  8'd1,   57,   1,   14,   16,  32};
        vecs[1] = '{16'd0, 16'd0, 16'd3, 16'd0, 4'd5, 4'd6, 4'd7,  8'd3,   19,   3,    9,    0,  18};
        vecs[2] = '{16'd3, 16'd0, 16'd0, 16'd0, 4'd1, 4'd2, 4'd3,  8'd5,    2,   0,    0,    0,   0};
        vecs[3] = '{16'd2, 16'd1, 16'd0, 16'd2, 4'd9, 4'd10, 4'd11, 8'd2,  37,   2,    6,   12,   0};
        vecs[4] = '{16'd0, 16'd2, 16'd1, 16'd1, 4'd3, 4'd4, 4'd5,  8'd255, 2041, 255, 1020, 1020, 510};
        vecs[5] = '{16'd0, 16'd0, 16'd0, 16'd1, 4'd1, 4'd2, 4'd3,  8'd1,    3,   1,    1,    0,   0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        drive_cfg(vecs[0]);
        idle_pat = 4'd3;
        repeat (3) @(negedge clk);
        check("reset_dclk", data_clock, 0);
        check("reset_pat", dat_pat, 3);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_bursts", bursts_done, 0);
        rst = 1'b0;
        idle_pat = 4'd5;
        @(negedge clk);
        check("idle_pat_follow", dat_pat, 5);

        for (int i = 0; i < 6; i++) begin
            drive_cfg(vecs[i]);
            run_seq(5000, vecs[i].pp, vecs[i].yp, dk, rs, pc, yc, bd, bz);
            check($sformatf("v%0d_done_cycle", i), dk, vecs[i].e_done);
            check($sformatf("v%0d_bursts", i), bd, vecs[i].e_bursts);
            check($sformatf("v%0d_rises", i), rs, vecs[i].e_rises);
            check($sformatf("v%0d_pre_cycles", i), pc, vecs[i].e_pre);
            check($sformatf("v%0d_pay_cycles", i), yc, vecs[i].e_pay);
            check($sformatf("v%0d_busy_at_done", i), bz, 1);
            @(negedge clk);
            check($sformatf("v%0d_busy_after", i), busy, 0);
            check($sformatf("v%0d_done_after", i), done, 0);
        end

        // Continuous bursts, abort after 20 completed.
        clk_div = 16'd0; pre_len = 16'd0; pay_len = 16'd2; gap_len = 16'd1;
        pre_pat = 4'd1; pay_pat = 4'd2; idle_pat = 4'd4; burst_cnt = 8'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k < 123; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("cont_bursts_before_abort", bursts_done, 20);
        check("cont_busy_before_abort", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_dclk", data_clock, 0);
        check("abort_pat", dat_pat, 4);
        check("abort_done", done, 0);
        check("abort_bursts_hold", bursts_done, 20);
        @(negedge clk);
        if (done) ndone++;
        check("cont_no_done", ndone, 0);

        // start and abort together in IDLE: abort wins; then a lone abort in IDLE.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", busy, 0);
        check("start_abort_bursts", bursts_done, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Config changes and a second start while busy take no effect on the active run.
        clk_div = 16'd1; pre_len = 16'd0; pay_len = 16'd2; gap_len = 16'd0;
        pre_pat = 4'd1; pay_pat = 4'd6; idle_pat = 4'd0; burst_cnt = 8'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dk = -1; c6 = 0; c9 = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (dat_pat == 4'd6) c6++;
            if (dat_pat == 4'd9) c9++;
            if (done) begin
                dk = k;
                break;
            end
            if (k == 3) begin
                pay_pat = 4'd9; clk_div = 16'd0; pay_len = 16'd5; start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        check("midrun_done_cycle", dk, 9);
        check("midrun_old_pat_cycles", c6, 8);
        check("midrun_new_pat_cycles", c9, 0);
        check("midrun_bursts", bursts_done, 1);
        run_seq(200, 4'd1, 4'd9, dk, rs, pc, yc, bd, bz);
        check("newcfg_done_cycle", dk, 11);
        check("newcfg_pay_cycles", yc, 10);
        check("newcfg_rises", rs, 5);
        @(negedge clk);

        // Synchronous reset in the middle of the payload.
        clk_div = 16'd0; pre_len = 16'd0; pay_len = 16'd3; gap_len = 16'd0;
        pre_pat = 4'd1; pay_pat = 4'd5; idle_pat = 4'd7; burst_cnt = 8'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("prerst_bursts", bursts_done, 1);
        check("prerst_pat", dat_pat, 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dclk", data_clock, 0);
        check("midrst_pat", dat_pat, 7);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_bursts", bursts_done, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef BURST_SYNC_EN
        // Sync pulse lands on the third data_clock rise of each 6-bit burst.
        clk_div = 16'd0; pre_len = 16'd2; pay_len = 16'd4; gap_len = 16'd0;
        pre_pat = 4'd1; pay_pat = 4'd2; idle_pat = 4'd0; burst_cnt = 8'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prv = 1'b0; rs = 0; ndone = 0; c6 = -1; c9 = -1; dk = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (data_clock && !prv) rs++;
            if (sync_pulse) begin
                ndone++;
                if (!(data_clock && !prv)) check("sync_on_rise", 0, 1);
                if (ndone == 1) c6 = rs;
                if (ndone == 2) c9 = rs;
            end
            prv = data_clock;
            if (done) begin
                dk = k;
                break;
            end
        end
        check("sync_count", ndone, 2);
        check("sync_first_rise", c6, 3);
        check("sync_second_rise", c9, 9);
        check("sync_done_cycle", dk, 25);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
